// File: rtl/audio_out_unit.sv
// audio_out_unit: captures audio samples from the datapath over a 4-phase
// req/ack handshake, queues them in a FIFO, plays one sample per sample tick
// and turns the playing sample into a 1-bit PWM stream. After the program
// signals finish, done rises once every queued sample has been consumed.
module audio_out_unit #(
    parameter int WIDTH      = 11,
    parameter int DEPTH      = 16,
    parameter int SAMPLE_DIV = 1136
) (
    input  logic                     clkFPGA,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     req,
    input  logic                     finish,
    output logic                     ack,
    output logic                     pwm_out,
    output logic [WIDTH-1:0]         level,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               underrun_cnt,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_t;

    hs_state_t          state_q, state_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;

    logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick;

    logic [WIDTH-1:0]   level_q;
    logic [WIDTH-1:0]   pwm_cnt_q;
    logic               pwm_q;
    logic [7:0]         underrun_q, underrun_d;
    logic               finish_latch_q;
    logic               done_q, done_d;

    logic               push;
    logic               pop;
    logic               has_room;

    assign tick     = (tick_cnt_q == CW'(SAMPLE_DIV - 1));
    assign pop      = tick && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign has_room = (count_q < (AW+1)'(DEPTH)) || pop;

    // Handshake FSM next state and the FIFO write strobe it produces.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && has_room) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, occupancy, tick counter, underrun counter and done.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
        underrun_d = underrun_q;
        // Underruns stop counting once playback is declared complete.
        if (tick && (count_q == '0) && !done_q && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end
        done_d = done_q || (finish_latch_q && (count_q == '0) && (state_q == IDLE));
    end

    // Sample storage: written on push, no reset so it maps onto block RAM.
    always_ff @(posedge clkFPGA) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // Control state registers and the registered FIFO read into level.
    always_ff @(posedge clkFPGA) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            tick_cnt_q     <= '0;
            level_q        <= '0;
            underrun_q     <= '0;
            finish_latch_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            tick_cnt_q     <= tick_cnt_d;
            underrun_q     <= underrun_d;
            finish_latch_q <= finish_latch_q || finish;
            done_q         <= done_d;
            if (pop) begin
                level_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // PWM: free-running ramp compared against the playing sample.
    always_ff @(posedge clkFPGA) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + WIDTH'(1);
            pwm_q     <= (pwm_cnt_q < level_q);
        end
    end

    assign ack          = (state_q == ACK);
    assign pwm_out      = pwm_q;
    assign level        = level_q;
    assign fifo_count   = count_q;
    assign underrun_cnt = underrun_q;
    assign done         = done_q;

endmodule

// File: tb/tb_audio_out_unit.sv
// Bench for audio_out_unit: a queue-based behavioural model runs alongside
// the design and every output is compared each cycle, plus directed checks
// for handshake latency, back-pressure, underrun, PWM duty, drain and reset.
module tb_audio_out_unit;

    localparam int WIDTH = 11;
    localparam int DEPTH = 4;
    localparam int SDIV  = 64;
    localparam int PWM_P = 2048;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] sample_in = '0;
    logic             req = 1'b0;
    logic             finish = 1'b0;
    logic             ack;
    logic             pwm_out;
    logic [WIDTH-1:0] level;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0]       underrun_cnt;
    logic             done;

    always #5 clk = ~clk;

    audio_out_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SAMPLE_DIV(SDIV)) dut (
        .clkFPGA      (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .req          (req),
        .finish       (finish),
        .ack          (ack),
        .pwm_out      (pwm_out),
        .level        (level),
        .fifo_count   (fifo_count),
        .underrun_cnt (underrun_cnt),
        .done         (done)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_q[$];
    int m_tick_ctr, m_level, m_under, m_pwm_ph;
    bit m_ack, m_latch, m_done, m_pwm, m_tick_now;
    bit m_pop, m_push, m_cond;

    task automatic model_step();
        if (rst) begin
            m_q.delete();
            m_tick_ctr = 0; m_level = 0; m_under = 0; m_pwm_ph = 0;
            m_ack = 0; m_latch = 0; m_done = 0; m_pwm = 0; m_tick_now = 0;
        end else begin
            m_tick_now = (m_tick_ctr == SDIV - 1);
            m_pop  = m_tick_now && (m_q.size() > 0);
            m_push = !m_ack && req && ((m_q.size() - int'(m_pop)) < DEPTH);
            m_cond = m_latch && (m_q.size() == 0) && !m_ack;
            if (m_tick_now && m_q.size() == 0 && !m_done && m_under < 255) m_under++;
            m_pwm    = (m_pwm_ph < m_level);
            m_pwm_ph = (m_pwm_ph + 1) % PWM_P;
            if (m_pop)  m_level = m_q.pop_front();
            if (m_push) m_q.push_back(int'(sample_in));
            m_ack      = m_ack ? req : m_push;
            m_done     = m_done || m_cond;
            m_latch    = m_latch || finish;
            m_tick_ctr = (m_tick_ctr + 1) % SDIV;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit cyc_en = 0;
    initial forever begin
        @(negedge clk);
        if (cyc_en) begin
            check_val("cyc_ack",   ack,          m_ack);
            check_val("cyc_count", fifo_count,   m_q.size());
            check_val("cyc_level", level,        m_level);
            check_val("cyc_under", underrun_cnt, m_under);
            check_val("cyc_done",  done,         m_done);
            check_val("cyc_pwm",   pwm_out,      m_pwm);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int k;
        repeat (n) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!m_tick_now && k < SDIV + 4);
            if (!m_tick_now) check_val("tick_wait", 0, 1);
        end
    endtask

    task automatic handshake(input int v);
        int k;
        logic [31:0] vv;
        vv = v;
        sample_in = vv[WIDTH-1:0];
        req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack && k < 4 * SDIV);
        if (!ack) check_val("hs_ack_rise", 0, 1);
        req = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ack && k < 5);
        if (ack) check_val("hs_ack_fall", 1, 0);
    endtask

    task automatic pwm_window(input int v, input string tag);
        int highs;
        handshake(v);
        wait_ticks(1);
        repeat (2) @(negedge clk);
        highs = 0;
        repeat (PWM_P) begin
            @(negedge clk);
            if (pwm_out) highs++;
        end
        check_val(tag, highs, v);
    endtask

    int s[4];
    int v5, a, b, c, r;

    initial begin
        // 1. reset and single capture
        do_reset();
        cyc_en = 1;
        check_val("rst_ack", ack, 0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_done", done, 0);
        sample_in = 11'h2A5;
        req = 1'b1;
        @(negedge clk);
        check_val("t1_ack_latency", ack, 1);
        check_val("t1_count", fifo_count, 1);
        req = 1'b0;
        @(negedge clk);
        check_val("t1_ack_drop", ack, 0);
        wait_ticks(1);
        check_val("t1_level", level, 11'h2A5);
        check_val("t1_count_pop", fifo_count, 0);

        // 2. back-pressure
        wait_ticks(1);
        for (int i = 0; i < 4; i++) begin
            s[i] = int'($urandom_range(1, 2047));
            handshake(s[i]);
        end
        check_val("t2_full", fifo_count, 4);
        v5 = int'($urandom_range(1, 2047));
        sample_in = v5[WIDTH-1:0];
        req = 1'b1;
        repeat (5) @(negedge clk);
        check_val("t2_bp_ack", ack, 0);
        check_val("t2_bp_count", fifo_count, 4);
        wait_ticks(1);
        check_val("t2_ack_rise", ack, 1);
        check_val("t2_count_same", fifo_count, 4);
        check_val("t2_level", level, s[0]);
        req = 1'b0;
        wait_ticks(5);
        check_val("t2_drained", fifo_count, 0);
        check_val("t2_last", level, v5);

        // random req/data traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            sample_in = WIDTH'($urandom);
            if ($urandom_range(0, 2) == 0) req = ~req;
        end
        req = 1'b0;
        wait_ticks(DEPTH + 1);

        // 3. underrun
        do_reset();
        handshake(100);
        wait_ticks(1);
        check_val("t3_level", level, 100);
        wait_ticks(3);
        check_val("t3_level_hold", level, 100);
        check_val("t3_under3", underrun_cnt, 3);
        wait_ticks(300);
        check_val("t3_under_sat", underrun_cnt, 255);

        // 4. PWM duty
        pwm_window(512, "t4_duty_512");
        pwm_window(0, "t4_duty_0");
        pwm_window(2047, "t4_duty_max");
        r = int'($urandom_range(1, 2046));
        pwm_window(r, "t4_duty_rand");

        // 5. finish and drain
        do_reset();
        a = int'($urandom_range(1, 2047));
        b = int'($urandom_range(1, 2047));
        c = int'($urandom_range(1, 2047));
        handshake(a);
        handshake(b);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        @(negedge clk);
        check_val("t5_done_early", done, 0);
        wait_ticks(1);
        check_val("t5_done_pop1", done, 0);
        check_val("t5_count1", fifo_count, 1);
        wait_ticks(1);
        check_val("t5_done_pop2", done, 0);
        check_val("t5_level_b", level, b);
        @(negedge clk);
        check_val("t5_done_set", done, 1);
        wait_ticks(3);
        check_val("t5_done_hold", done, 1);
        check_val("t5_under_frozen", underrun_cnt, 0);
        handshake(c);
        check_val("t5_done_after_req", done, 1);
        wait_ticks(1);
        check_val("t5_level_c", level, c);

        // 6. reset mid-handshake
        do_reset();
        handshake(int'($urandom_range(1, 2047)));
        handshake(int'($urandom_range(1, 2047)));
        wait_ticks(1);
        handshake(int'($urandom_range(1, 2047)));
        sample_in = WIDTH'($urandom);
        req = 1'b1;
        @(negedge clk);
        check_val("t6_ack_pre", ack, 1);
        check_val("t6_count_pre", fifo_count, 3);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_ack", ack, 0);
        check_val("t6_rst_count", fifo_count, 0);
        check_val("t6_rst_level", level, 0);
        check_val("t6_rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("t6_recapture_ack", ack, 1);
        check_val("t6_recapture_count", fifo_count, 1);
        req = 1'b0;
        repeat (3) @(negedge clk);

        cyc_en = 0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/audio_out_unit.md
Name: audio_out_unit

Overview:
- Downstream consumer of the processor datapath's audio outputs.
- Captures 11-bit samples from R6_audio using a 4-phase handshake: R14_flag is the request; this block's ack drives the datapath's R13_flag input.
- Buffers samples in a FIFO and releases one sample per sample tick.
- Converts the current sample to a 1-bit PWM stream for the board's audio output.
- Reports drain-complete after the program signals finish.

Parameters:
- WIDTH, 11, sample width in bits; equals the R6_audio width.
- DEPTH, 16, FIFO depth in samples; power of two, at least 2.
- SAMPLE_DIV, 1136, clkFPGA cycles per sample tick; at least 2.

Ports:
- clkFPGA  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- sample_in  input  WIDTH  sample value; connects to R6_audio.
- req  input  1  sample-valid request; connects to R14_flag.
- finish  input  1  program-finished indication; connects to finish.
- ack  output  1  capture acknowledge; connects to the datapath R13_flag input.
- pwm_out  output  1  PWM audio bit.
- level  output  WIDTH  sample currently being played.
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy, range 0..DEPTH.
- underrun_cnt  output  8  saturating count of empty-FIFO ticks.
- done  output  1  finish seen and all samples consumed.

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clkFPGA.
  - rst is sampled synchronously and overrides everything else, including a reset asserted mid-handshake.
- Reset values:
  - ack=0, pwm_out=0, level=0, fifo_count=0, underrun_cnt=0, done=0.
  - Handshake FSM=IDLE, FIFO pointers=0, tick counter=0, PWM counter=0, finish latch=0.
- Handshake FSM (states IDLE, ACK):
  - IDLE, req=1, fifo_count<DEPTH: write sample_in into the FIFO this edge; next state ACK. ack=1 from the following cycle, so latency is 1 cycle.
  - IDLE, req=1, FIFO full: stay in IDLE with ack=0 (back-pressure). No write occurs. Capture happens on the first edge after space frees.
  - IDLE, req=0: stay in IDLE.
  - ACK: ack=1. Stay while req=1; go to IDLE when req=0. ack=0 the cycle after req is seen low.
  - A held req produces exactly one write per handshake.
- Sample tick:
  - The tick counter counts 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted for one cycle when the counter equals SAMPLE_DIV-1.
- On tick:
  - FIFO non-empty: pop the head into level; level updates on that edge.
  - FIFO empty: level holds its old value; underrun_cnt increments and saturates at 255.
  - underrun_cnt does not increment when done=1.
- Simultaneous push and pop: both occur in the same cycle; fifo_count is unchanged; pointers wrap modulo DEPTH.
  - Pop on a full FIFO with a pending req: the push is allowed that same cycle.
- PWM:
  - A free-running WIDTH-bit counter pwm_cnt (0..2^WIDTH-1) wraps.
  - pwm_out = (pwm_cnt < level), registered.
  - level=0 gives pwm_out constantly 0.
  - level=2^WIDTH-1 gives pwm_out high for 2^WIDTH-1 of every 2^WIDTH cycles.
- Finish and done:
  - finish=1 sets a sticky latch, cleared only by rst.
  - done=1 when latch=1, fifo_count=0, and the FSM is in IDLE; registered, 1 cycle after the condition holds.
  - Once set, done holds until rst.
  - A req arriving after done is still captured, but done stays set.
- Arithmetic: all counters are unsigned; no width truncation on fifo_count (it has one extra bit so it can represent DEPTH).

Test Plan:
1. Reset and single capture (SAMPLE_DIV=8):
   - Stimulus: rst for 2 cycles, then sample_in=11'h2A5, req=1.
   - Required: ack=1 one cycle after req, fifo_count=1.
   - Stimulus: drop req.
   - Required: ack=0 next cycle.
   - Required: on the next tick, level=11'h2A5 and fifo_count=0.
2. Back-pressure (DEPTH=4, SAMPLE_DIV=1000):
   - Stimulus: four handshakes fill the FIFO to fifo_count=4, then a fifth req=1.
   - Required: ack stays 0.
   - Required: at the next tick, a simultaneous pop and push occur, ack rises, fifo_count stays 4, and level equals sample #1.
3. Underrun:
   - Stimulus: no samples for 3 ticks after level=11'd100.
   - Required: level stays 100 and underrun_cnt=3.
   - Stimulus: 300 empty ticks.
   - Required: underrun_cnt=255.
4. PWM duty:
   - Stimulus: level=11'd512.
   - Required: over one 2048-cycle PWM period, pwm_out is high for exactly 512 cycles.
   - Stimulus: level=0.
   - Required: pwm_out is always 0.
5. Finish and drain:
   - Stimulus: 2 samples queued, then a finish pulse of 1 cycle.
   - Required: done=0 until the second pop.
   - Required: done=1 one cycle after fifo_count reaches 0, and it holds.
   - Required: underrun_cnt is frozen afterwards.
6. Reset mid-handshake:
   - Stimulus: rst asserted while ack=1 with fifo_count=3.
   - Required: next cycle ack=0, fifo_count=0, level=0, done=0.
   - Required: if req is still 1 after rst is released, a new capture occurs.
